muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV M-extension execute unit, parametrised in operand width; sits beside the single-cycle ALU in EX.
- Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles.
- Uses a valid/ready handshake on both sides, so the pipeline stalls on `in_ready`/`out_valid`.
- Accepts one operation at a time; a flush from branch resolution aborts the operation in flight.

Parameters:
- XLEN, 32, operand/result width; must be even and at least 8.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Asynchronous assert, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; high only in IDLE.
- funct3  in  3  M-op select:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_data  in  XLEN  operand A (multiplicand / dividend).
- rs2_data  in  XLEN  operand B (multiplier / divisor).
- flush  in  1  synchronous abort of any in-flight or completed-unread operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  operation result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state = IDLE
  - out_valid = 0, result = 0, busy = 0
  - in_ready = 1 once rst_n deasserts
- States: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - Accept when in_valid && in_ready && !flush.
  - Latch funct3 and operands; record signA/signB per op:
    - MULH, DIV, REM: both operands signed.
    - MULHSU: A signed, B unsigned.
    - All other ops: both unsigned.
  - Convert operands to XLEN-bit magnitudes.
  - Special cases on a divide op go straight to DONE:
    - Divisor == 0: DIV/DIVU give all-ones; REM/REMU give dividend.
    - Signed overflow (DIV/REM, A = most-negative, B = -1): DIV gives A; REM gives 0.
  - Otherwise go to CALC with counter = XLEN.
- CALC, one bit per cycle, XLEN cycles:
  - Multiply: shift-add into a 2*XLEN accumulator, LSB-first over the multiplier.
  - Divide: restoring — shift remainder left, trial-subtract divisor, set quotient bit.
  - When counter reaches 1, go to FIXUP.
- FIXUP, one cycle:
  - Negate product if signA^signB.
  - Negate quotient if signA^signB; negate remainder if signA.
  - Select output:
    - MUL: low half of the product.
    - MULH/MULHSU/MULHU: high half of the product.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Register the selected value into result; go to DONE.
- DONE:
  - out_valid = 1; result is held stable until out_ready is sampled high.
  - On out_ready, go to IDLE next cycle.
  - No new op is accepted in the handshake cycle.
- Latency, accept edge = cycle T:
  - Normal op: out_valid high in cycle T+XLEN+2.
  - Special-case divide: out_valid high in cycle T+1.
- Throughput: at most one op per XLEN+3 cycles.
- Flush:
  - In any state, flush returns to IDLE next edge and drops out_valid.
  - result keeps its last value.
  - flush in the same cycle as in_valid: the op is not accepted.
- out_ready while out_valid is low is ignored.
- Operand inputs are don't-care outside the accept cycle.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - Multiply leaves CALC as soon as the remaining multiplier magnitude is zero, going to FIXUP next cycle.
  - e.g. multiplier 3 finishes CALC after 2 iterations → out_valid at T+4.
  - Division timing is unchanged.
- Undefined: fixed XLEN-cycle CALC for every op. This gives deterministic latency for the scoreboard.

Decomposition:
- Package muldiv_pkg holds:
  - funct3 localparams (MULDIV_MUL … MULDIV_REMU).
  - State encoding (2-bit) for IDLE/CALC/FIXUP/DONE.
  - Helper function is_div(funct3).
- One sub-module, muldiv_negate: parametrised width, conditional two's-complement. Instantiated for:
  - operand abs() on A and B in IDLE;
  - result fix-up of product, quotient and remainder in FIXUP.
- FSM, datapath and counter stay in muldiv_unit.

Test Plan:
- MUL, A=7, B=-3 (0xFFFFFFFD): result 0xFFFFFFEB; out_valid exactly at T+34 with macro off.
- MULH, A=0x80000000, B=0x80000000 → 0x40000000; MULHU, A=0xFFFFFFFF, B=0xFFFFFFFF → 0xFFFFFFFE; MULHSU, A=-1, B=2 → 0xFFFFFFFF.
- Divide specials, each with out_valid at T+1:
  - DIV 100/0 → 0xFFFFFFFF; REMU 100/0 → 100.
  - DIV 0x80000000/-1 → 0x80000000; REM 0x80000000/-1 → 0.
- DIV -7/2 → -3 (0xFFFFFFFD); REM -7/2 → -1; DIVU 7/2 → 3. Check out_valid and result held 5 cycles with out_ready low, then in_ready 1 cycle after handshake.
- Assert flush at T+10 of a DIV: back in IDLE, out_valid never rises. Assert flush together with in_valid: no accept. Next op computes correctly.
- Reset and early-out:
  - Drop rst_n mid-CALC: out_valid/result/busy go to 0 immediately, without waiting for a clock edge.
  - With MULDIV_EARLY_OUT_EN: MUL 5×3 → 15, out_valid at T+4.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV M-extension multiply/divide unit:
// funct3 op codes, FSM state encoding and op-class helper.
package muldiv_pkg;

  localparam logic [2:0] MULDIV_MUL    = 3'b000;
  localparam logic [2:0] MULDIV_MULH   = 3'b001;
  localparam logic [2:0] MULDIV_MULHSU = 3'b010;
  localparam logic [2:0] MULDIV_MULHU  = 3'b011;
  localparam logic [2:0] MULDIV_DIV    = 3'b100;
  localparam logic [2:0] MULDIV_DIVU   = 3'b101;
  localparam logic [2:0] MULDIV_REM    = 3'b110;
  localparam logic [2:0] MULDIV_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } muldiv_state_e;

  function automatic logic is_div(input logic [2:0] f);
    return f[2];
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negation, used for operand magnitudes and
// for sign fix-up of product, quotient and remainder.
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] data_i,
  input  logic         neg_i,
  output logic [W-1:0] data_o
);

  assign data_o = neg_i ? (~data_i + W'(1)) : data_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV M-extension execute unit: shift-add multiply and restoring
// divide, one bit per cycle. Define MULDIV_EARLY_OUT_EN to let multiplies
// leave CALC once the remaining multiplier is zero.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  muldiv_state_e     state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              out_valid_q;
  logic [XLEN-1:0]   result_q;
  logic [2:0]        op_q;
  logic              sgn_a_q, sgn_b_q;
  logic [2*XLEN-1:0] acc_q, acc_d, mcand_q;
  logic [XLEN-1:0]   opb_q;

  logic              accept, sgn_a_d, sgn_b_d, div_zero, div_ovf, special, early_done;
  logic [XLEN-1:0]   abs_a, abs_b, special_res, quot_fix, rem_fix, fix_res;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN:0]     rem_sh, diff;

  assign accept    = in_valid && (state_q == ST_IDLE) && !flush;
  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;

  always_comb begin
    sgn_a_d  = ((funct3 == MULDIV_MULH) || (funct3 == MULDIV_MULHSU) ||
                (funct3 == MULDIV_DIV)  || (funct3 == MULDIV_REM)) && rs1_data[XLEN-1];
    sgn_b_d  = ((funct3 == MULDIV_MULH) || (funct3 == MULDIV_DIV) ||
                (funct3 == MULDIV_REM)) && rs2_data[XLEN-1];
    div_zero = (rs2_data == '0);
    div_ovf  = ((funct3 == MULDIV_DIV) || (funct3 == MULDIV_REM)) &&
               (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    special  = is_div(funct3) && (div_zero || div_ovf);
    // funct3[1] separates REM/REMU from DIV/DIVU
    if (div_zero) special_res = funct3[1] ? rs1_data : '1;
    else          special_res = funct3[1] ? '0 : rs1_data;
  end

  muldiv_negate #(.W(XLEN)) u_abs_a (.data_i(rs1_data), .neg_i(sgn_a_d), .data_o(abs_a));
  muldiv_negate #(.W(XLEN)) u_abs_b (.data_i(rs2_data), .neg_i(sgn_b_d), .data_o(abs_b));

  muldiv_negate #(.W(2*XLEN)) u_fix_prod (.data_i(acc_q), .neg_i(sgn_a_q ^ sgn_b_q), .data_o(prod_fix));
  muldiv_negate #(.W(XLEN)) u_fix_quot (.data_i(acc_q[XLEN-1:0]), .neg_i(sgn_a_q ^ sgn_b_q),
                                        .data_o(quot_fix));
  muldiv_negate #(.W(XLEN)) u_fix_rem (.data_i(acc_q[2*XLEN-1:XLEN]), .neg_i(sgn_a_q),
                                       .data_o(rem_fix));

  // Divide packs {remainder, dividend/quotient} into acc_q; multiply accumulates the product there
  always_comb begin
    rem_sh = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff   = rem_sh - {1'b0, opb_q};
    if (is_div(op_q)) begin
      if (diff[XLEN]) acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      else            acc_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_d = acc_q + (opb_q[0] ? mcand_q : '0);
    end
  end

  always_comb begin
    case (op_q)
      MULDIV_MUL:                 fix_res = prod_fix[XLEN-1:0];
      MULDIV_DIV, MULDIV_DIVU:    fix_res = quot_fix;
      MULDIV_REM, MULDIV_REMU:    fix_res = rem_fix;
      default:                    fix_res = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

`ifdef MULDIV_EARLY_OUT_EN
  assign early_done = !is_div(op_q) && (opb_q[XLEN-1:1] == '0);
`else
  assign early_done = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= funct3;
      sgn_a_q <= sgn_a_d;
      sgn_b_q <= sgn_b_d;
      opb_q   <= abs_b;
      mcand_q <= {{XLEN{1'b0}}, abs_a};
      acc_q   <= is_div(funct3) ? {{XLEN{1'b0}}, abs_a} : '0;
    end else if (state_q == ST_CALC) begin
      acc_q   <= acc_d;
      mcand_q <= mcand_q << 1;
      if (!is_div(op_q)) opb_q <= opb_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            if (special) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              result_q    <= special_res;
            end else begin
              state_q <= ST_CALC;
              cnt_q   <= CNT_W'(XLEN);
            end
          end
        end
        ST_CALC: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if ((cnt_q == CNT_W'(1)) || early_done) state_q <= ST_FIXUP;
        end
        ST_FIXUP: begin
          result_q    <= fix_res;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        default: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (XLEN=32): reference model computes
// result and latency, checked when the unit raises out_valid.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb2, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    logic        ovf;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (f)
      3'b000: begin p = 64'(sa * sb2); r = p[31:0];  end
      3'b001: begin p = 64'(sa * sb2); r = p[63:32]; end
      3'b010: begin p = 64'(sa * ub);  r = p[63:32]; end
      3'b011: begin p = 64'(ua * ub);  r = p[63:32]; end
      3'b100: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: r = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
    if (f[2] && ((b == 0) || (!f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF))))
      return 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (!f[2]) begin
      logic [31:0] mag;
      int          n;
      mag = ((f == 3'b001) && b[31]) ? (32'h0 - b) : b;
      n   = 1;
      for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
      return n + 2;
    end
`endif
    return 34;
  endfunction

  // Issue one op, check latency/result, optionally hold out_ready low, then hand shake.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    exp_t e, got_e;
    int   k;
    bit   seen;
    e.res = model_res(f, a, b);
    e.lat = model_lat(f, a, b);
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 100) begin @(negedge clk); k++; end
    in_valid = 1'b1; funct3 = f; rs1_data = a; rs2_data = b;
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0; rs1_data = $urandom; rs2_data = $urandom; funct3 = 3'($urandom);
    k = 1; seen = 1'b0;
    while (k < 100) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
      @(posedge clk);
      k++;
    end
    got_e = sb.pop_front();
    chk($sformatf("lat f%0d", f), 64'(seen ? k : 0), 64'(got_e.lat));
    if (!seen) return;
    chk($sformatf("res f%0d %0h %0h", f, a, b), 64'(result), 64'(got_e.res));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_result", 64'(result), 64'(got_e.res));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("post_hs_valid", 64'(out_valid), 64'd0);
    chk("post_hs_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    funct3 = '0; rs1_data = '0; rs2_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 0);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'b010, 32'hFFFF_FFFF, 32'd2, 0);
    run_op(3'b100, 32'd100, 32'd0, 0);
    run_op(3'b111, 32'd100, 32'd0, 0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'b101, 32'd7, 32'd2, 0);
    run_op(3'b000, 32'd5, 32'd3, 0);

    // Flush a divide in flight at T+10
    @(negedge clk);
    in_valid = 1'b1; funct3 = 3'b100; rs1_data = 32'd100; rs2_data = 32'd7;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("pre_flush_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (out_valid) cnt++; end
    chk("flush_no_valid", 64'(cnt), 64'd0);

    // Flush together with in_valid: nothing accepted
    in_valid = 1'b1; flush = 1'b1; funct3 = 3'b000; rs1_data = 32'd9; rs2_data = 32'd9;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_accept_busy", 64'(busy), 64'd0);
    run_op(3'b000, 32'd6, 32'd7, 0);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
      run_op(3'($urandom), ra, rb, 0);
    end
    run_op(3'b101, 32'd1000, 32'd7, 0);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    in_valid = 1'b1; funct3 = 3'b000; rs1_data = 32'd11; rs2_data = 32'd13;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    chk("pre_rst_result", 64'(result), 64'd142);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_result", 64'(result), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    run_op(3'b110, 32'd17, 32'd5, 0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
